sar_oversample_ctrl: RTL and testbench
======================================

// Module: sar_oversample_ctrl
// PURPOSE
//  Digital stage directly downstream of the SAR ADC top: issues GO to the converter,
//  captures RESULT on each VALID rising edge and accumulates 2^OSR_LOG2 conversions.
//  Presents the sum and the averaged word on a valid/ready output port.
//  Watchdog aborts a burst if the converter never reports VALID.
// PARAMETERS
//  NBITS     8   ADC result width
//  MAXLOG    4   max oversampling exponent; accumulator is NBITS+MAXLOG bits
//  TOUT_CYC  64  CLK cycles allowed between ADC_GO and ADC_VALID rise before abort
// PORTS
//  CLK         in   1             single clock (same buffered CLK as SAR digital)
//  RST         in   1             async, active-high reset
//  START       in   1             request one burst; sampled in IDLE only
//  OSR_LOG2    in   clog2(MAXLOG+1)  burst length 2^OSR_LOG2; clamped to MAXLOG
//  ADC_GO      out  1             to SARADC GO
//  ADC_VALID   in   1             from SARADC VALID
//  ADC_RESULT  in   NBITS         from SARADC RESULT
//  OUT_VALID   out  1             burst result available
//  OUT_READY   in   1             consumer accepts result
//  OUT_SUM     out  NBITS+MAXLOG  raw accumulated sum, zero-extended
//  OUT_AVG     out  NBITS         OUT_SUM >> OSR_LOG2 (latched exponent)
//  BUSY        out  1             high in any state but IDLE
//  TIMEOUT     out  1             sticky; set on watchdog abort, cleared by next START
// BEHAVIOUR
//  - Reset: ADC_GO=0, OUT_VALID=0, OUT_SUM=0, OUT_AVG=0, BUSY=0, TIMEOUT=0, state IDLE,
//    accumulator/counters 0, VALID edge register 0. Reset mid-burst drops the burst.
//  - FSM IDLE -> GO -> WAIT -> (GO | OUT) -> IDLE:
//    IDLE: START=1 latches clamped OSR_LOG2, clears acc, count, TIMEOUT; -> GO.
//    GO:   ADC_GO=1 for exactly one cycle; watchdog counter cleared; -> WAIT.
//    WAIT: rising edge of ADC_VALID (registered prev=0, now=1) adds ADC_RESULT to acc,
//          count+1; if count reaches 2^k -> OUT, else -> GO. Level-high VALID without
//          an edge is ignored. Watchdog hits TOUT_CYC-1 without edge -> TIMEOUT=1, IDLE,
//          no OUT_VALID.
//    OUT:  OUT_VALID=1, OUT_SUM/OUT_AVG registered on entry and stable until handshake;
//          OUT_VALID && OUT_READY -> IDLE next cycle. ADC_VALID ignored in OUT.
//  - Latency: START to first ADC_GO = 1 cycle; last VALID edge to OUT_VALID = 1 cycle.
//  - Back-to-back: START high while in OUT is ignored; new burst begins only when
//    sampled in IDLE (earliest cycle after the handshake).
//  - Width: acc never overflows (2^MAXLOG * (2^NBITS-1) fits NBITS+MAXLOG).
//  - OSR_LOG2=0: single conversion, OUT_AVG == ADC_RESULT.
//  - Edge and watchdog expiry in same cycle: edge wins.
// CONFIGURATION
//  SAR_OSC_WINDOW_EN defined: extra inputs WIN_LO/WIN_HI [NBITS-1:0] and output
//   OUT_INWIN (1 bit) registered with OUT_AVG: 1 iff WIN_LO <= OUT_AVG <= WIN_HI;
//   reset 0. Not defined: those ports and their logic are absent.
// STRUCTURE
//  - Package sar_osc_pkg: state enum (IDLE, GO, WAIT, OUT), width localparams
//    (ACCW = NBITS+MAXLOG, counter widths for MAXLOG and TOUT_CYC).
//  - One sub-module sar_osc_watchdog: clearable counter with expiry pulse; rest flat.
// TESTING
//  - NBITS=8, k=2, results 10,20,30,40 -> OUT_SUM=100, OUT_AVG=25, ADC_GO pulsed 4x.
//  - k=4, all results 255 -> OUT_SUM=4080, OUT_AVG=255, no overflow.
//  - k=1, ADC_VALID never rises -> after 64 cycles TIMEOUT=1, BUSY=0, OUT_VALID stays 0;
//    next START clears TIMEOUT.
//  - OUT_READY held 0 for 10 cycles -> OUT_VALID/OUT_SUM stable, START ignored, ADC_GO 0.
//  - RST asserted mid-WAIT after 2 of 4 samples -> all outputs 0; next burst sums only
//    new samples.
//  - SAR_OSC_WINDOW_EN, WIN 20..30, avg 25 -> OUT_INWIN=1; avg 31 -> OUT_INWIN=0.

Source files
------------

// File: rtl/sar_osc_pkg.sv
// sar_osc_pkg
//   Shared types and width helpers for the SAR oversampling controller.
//   - state_e    : controller FSM states (IDLE, GO, WAIT, OUT)
//   - *_DEF      : default NBITS / MAXLOG / TOUT_CYC values
//   - ACCW       : accumulator width for the default parameter set
//   - kw_f/cw_f/tw_f : counter widths derived from MAXLOG and TOUT_CYC
package sar_osc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam int NBITS_DEF    = 8;
    localparam int MAXLOG_DEF   = 4;
    localparam int TOUT_CYC_DEF = 64;
    localparam int ACCW         = NBITS_DEF + MAXLOG_DEF;

    // Width of the OSR_LOG2 exponent field (holds 0..maxlog).
    function automatic int kw_f(input int maxlog);
        return (maxlog > 0) ? $clog2(maxlog + 1) : 1;
    endfunction

    // Width of the conversion counter (holds 0..2^maxlog).
    function automatic int cw_f(input int maxlog);
        return $clog2((1 << maxlog) + 1);
    endfunction

    // Width of the watchdog counter (holds 0..tout-1).
    function automatic int tw_f(input int tout);
        return (tout > 1) ? $clog2(tout) : 1;
    endfunction

endpackage

// File: rtl/sar_osc_watchdog.sv
// sar_osc_watchdog
//   Clearable up-counter with a combinational expiry flag.
//   Ports:
//     CLK, RST  clock / async active-high reset
//     clr       synchronous clear of the count (dominates en)
//     en        count enable; expire is only asserted while enabled
//     expire    high while enabled and the count equals TOUT_CYC-1
module sar_osc_watchdog
    import sar_osc_pkg::*;
#(
    parameter int TOUT_CYC = TOUT_CYC_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = tw_f(TOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expire = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sar_oversample_ctrl.sv
// sar_oversample_ctrl
//   Drives GO to the SAR converter, captures RESULT on each rising edge of
//   VALID and accumulates 2^OSR_LOG2 conversions, then presents the sum and
//   the averaged word on a valid/ready port. A watchdog aborts the burst if
//   VALID never rises after a GO.
//   Ports:
//     CLK, RST              clock / async active-high reset
//     START, OSR_LOG2       burst request and exponent (clamped to MAXLOG)
//     ADC_GO                one-cycle conversion request to the ADC
//     ADC_VALID, ADC_RESULT converter handshake and data
//     OUT_VALID, OUT_READY  result handshake
//     OUT_SUM, OUT_AVG      raw sum and sum >> exponent
//     BUSY                  any state other than IDLE
//     TIMEOUT               sticky watchdog abort flag, cleared by next START
//   Optional (macro SAR_OSC_WINDOW_EN): WIN_LO/WIN_HI inputs and OUT_INWIN,
//   high iff WIN_LO <= OUT_AVG <= WIN_HI, registered together with OUT_AVG.
module sar_oversample_ctrl
    import sar_osc_pkg::*;
#(
    parameter int NBITS    = NBITS_DEF,
    parameter int MAXLOG   = MAXLOG_DEF,
    parameter int TOUT_CYC = TOUT_CYC_DEF
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [kw_f(MAXLOG)-1:0]         OSR_LOG2,
    output logic                            ADC_GO,
    input  logic                            ADC_VALID,
    input  logic [NBITS-1:0]                ADC_RESULT,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [NBITS+MAXLOG-1:0]         OUT_SUM,
    output logic [NBITS-1:0]                OUT_AVG,
    output logic                            BUSY,
    output logic                            TIMEOUT
`ifdef SAR_OSC_WINDOW_EN
    ,
    input  logic [NBITS-1:0]                WIN_LO,
    input  logic [NBITS-1:0]                WIN_HI,
    output logic                            OUT_INWIN
`endif
);

    localparam int AW = NBITS + MAXLOG;
    localparam int KW = kw_f(MAXLOG);
    localparam int CW = cw_f(MAXLOG);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vprev_q;
    logic              timeout_q, timeout_d;
    logic [AW-1:0]     out_sum_q, out_sum_d;
    logic [NBITS-1:0]  out_avg_q, out_avg_d;

    logic              valid_edge;
    logic              wd_clr, wd_en, wd_expire;
    logic [AW-1:0]     acc_sum;
    logic [NBITS-1:0]  avg_new;
    logic [CW-1:0]     cnt_inc;
    logic [CW-1:0]     target;

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        return (k > KW'(MAXLOG)) ? KW'(MAXLOG) : k;
    endfunction

    // The sum of 2^k samples shifted right by k always fits NBITS.
    function automatic logic [NBITS-1:0] avg_of(input logic [AW-1:0] s,
                                                input logic [KW-1:0] k);
        return NBITS'(s >> k);
    endfunction

    assign valid_edge = ADC_VALID && !vprev_q;
    assign acc_sum    = acc_q + AW'(ADC_RESULT);
    assign avg_new    = avg_of(acc_sum, k_q);
    assign cnt_inc    = cnt_q + CW'(1);
    assign target     = CW'(1) << k_q;
    assign wd_clr     = (state_q == GO);
    assign wd_en      = (state_q == WAIT);

    sar_osc_watchdog #(
        .TOUT_CYC (TOUT_CYC)
    ) u_watchdog (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

`ifdef SAR_OSC_WINDOW_EN
    logic inwin_q, inwin_d;
    assign OUT_INWIN = inwin_q;
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        out_sum_d = out_sum_q;
        out_avg_d = out_avg_q;
`ifdef SAR_OSC_WINDOW_EN
        inwin_d   = inwin_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    k_d       = clamp_k(OSR_LOG2);
                    acc_d     = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = GO;
                end
            end
            GO: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A VALID edge takes priority over a simultaneous watchdog expiry.
                if (valid_edge) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == target) begin
                        out_sum_d = acc_sum;
                        out_avg_d = avg_new;
`ifdef SAR_OSC_WINDOW_EN
                        inwin_d   = (WIN_LO <= avg_new) && (avg_new <= WIN_HI);
`endif
                        state_d   = OUT;
                    end else begin
                        state_d = GO;
                    end
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            OUT: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            vprev_q   <= 1'b0;
            timeout_q <= 1'b0;
            out_sum_q <= '0;
            out_avg_q <= '0;
`ifdef SAR_OSC_WINDOW_EN
            inwin_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            vprev_q   <= ADC_VALID;
            timeout_q <= timeout_d;
            out_sum_q <= out_sum_d;
            out_avg_q <= out_avg_d;
`ifdef SAR_OSC_WINDOW_EN
            inwin_q   <= inwin_d;
`endif
        end
    end

    assign ADC_GO    = (state_q == GO);
    assign OUT_VALID = (state_q == OUT);
    assign BUSY      = (state_q != IDLE);
    assign TIMEOUT   = timeout_q;
    assign OUT_SUM   = out_sum_q;
    assign OUT_AVG   = out_avg_q;

endmodule

// File: tb/tb_sar_oversample_ctrl.sv
// tb_sar_oversample_ctrl
//   Self-checking bench for sar_oversample_ctrl (NBITS=8, MAXLOG=4,
//   TOUT_CYC=64). Expected sums/averages are queued when a burst is driven
//   and popped when OUT_VALID appears.
module tb_sar_oversample_ctrl;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [2:0]  OSR_LOG2;
    logic        ADC_GO;
    logic        ADC_VALID;
    logic [7:0]  ADC_RESULT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [11:0] OUT_SUM;
    logic [7:0]  OUT_AVG;
    logic        BUSY;
    logic        TIMEOUT;
`ifdef SAR_OSC_WINDOW_EN
    logic [7:0]  WIN_LO;
    logic [7:0]  WIN_HI;
    logic        OUT_INWIN;
`endif

    sar_oversample_ctrl #(
        .NBITS    (8),
        .MAXLOG   (4),
        .TOUT_CYC (64)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .OSR_LOG2   (OSR_LOG2),
        .ADC_GO     (ADC_GO),
        .ADC_VALID  (ADC_VALID),
        .ADC_RESULT (ADC_RESULT),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_SUM    (OUT_SUM),
        .OUT_AVG    (OUT_AVG),
        .BUSY       (BUSY),
        .TIMEOUT    (TIMEOUT)
`ifdef SAR_OSC_WINDOW_EN
        ,
        .WIN_LO     (WIN_LO),
        .WIN_HI     (WIN_HI),
        .OUT_INWIN  (OUT_INWIN)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int go_total = 0;
    logic [7:0] res_tab [16];
    int unsigned exp_sum_q [$];
    int unsigned exp_avg_q [$];

    always @(negedge CLK) begin
        if (ADC_GO === 1'b1) go_total++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits for GO, lets WAIT run one idle cycle, then gives one VALID edge.
    task automatic feed_sample(input logic [7:0] r, output bit ok);
        int t = 0;
        ok = 1'b1;
        while (ADC_GO !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (ADC_GO !== 1'b1) begin
            tests++; fails++;
            $display("FAIL go_wait: ADC_GO=%b after %0d cycles, required 1", ADC_GO, t);
            ok = 1'b0;
            return;
        end
        step();
        step();
        ADC_VALID  = 1'b1;
        ADC_RESULT = r;
        step();
        ADC_VALID  = 1'b0;
    endtask

    // Full burst using res_tab; optionally holds OUT_READY low for 'hold' cycles
    // while START and ADC_VALID are wiggled.
    task automatic run_burst(input int k, input int hold, input string name);
        int keff;
        int n;
        int unsigned sum;
        int unsigned es;
        int unsigned ea;
        int g0;
        bit ok;
        keff = (k > 4) ? 4 : k;
        n    = 1 << keff;
        sum  = 0;
        for (int i = 0; i < n; i++) sum += res_tab[i];
        exp_sum_q.push_back(sum);
        exp_avg_q.push_back(sum >> keff);

        g0       = go_total;
        START    = 1'b1;
        OSR_LOG2 = k[2:0];
        step();
        START    = 1'b0;
        tests++;
        if (ADC_GO !== 1'b1) begin
            fails++;
            $display("FAIL %s start_latency: ADC_GO=%b, required 1", name, ADC_GO);
        end

        for (int i = 0; i < n; i++) begin
            feed_sample(res_tab[i], ok);
            if (!ok) return;
        end

        tests++;
        if (OUT_VALID !== 1'b1) begin
            fails++;
            $display("FAIL %s out_latency: OUT_VALID=%b, required 1", name, OUT_VALID);
        end

        for (int c = 0; c < hold; c++) begin
            START      = 1'b1;
            ADC_VALID  = c[0];
            ADC_RESULT = 8'hFF;
            step();
            tests++;
            if (OUT_VALID !== 1'b1 || OUT_SUM !== 12'(sum) || ADC_GO !== 1'b0) begin
                fails++;
                $display("FAIL %s hold[%0d]: OUT_VALID=%b OUT_SUM=%0d ADC_GO=%b, required 1/%0d/0",
                         name, c, OUT_VALID, OUT_SUM, ADC_GO, sum);
            end
        end
        START     = 1'b0;
        ADC_VALID = 1'b0;

        if (exp_sum_q.size() == 0 || exp_avg_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard: queue empty, required an entry", name);
        end else begin
            es = exp_sum_q.pop_front();
            ea = exp_avg_q.pop_front();
            tests++;
            if (OUT_SUM !== 12'(es)) begin
                fails++;
                $display("FAIL %s sum: got %0d, required %0d", name, OUT_SUM, es);
            end
            tests++;
            if (OUT_AVG !== 8'(ea)) begin
                fails++;
                $display("FAIL %s avg: got %0d, required %0d", name, OUT_AVG, ea);
            end
`ifdef SAR_OSC_WINDOW_EN
            tests++;
            if (OUT_INWIN !== ((8'(ea) >= WIN_LO) && (8'(ea) <= WIN_HI))) begin
                fails++;
                $display("FAIL %s inwin: got %b for avg %0d window %0d..%0d",
                         name, OUT_INWIN, ea, WIN_LO, WIN_HI);
            end
`endif
        end

        tests++;
        if (go_total - g0 != n) begin
            fails++;
            $display("FAIL %s go_count: got %0d pulses, required %0d", name, go_total - g0, n);
        end

        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        tests++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake: OUT_VALID=%b BUSY=%b, required 0/0", name, OUT_VALID, BUSY);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        tests++;
        if (ADC_GO !== 1'b0 || OUT_VALID !== 1'b0 || OUT_SUM !== 12'd0 ||
            OUT_AVG !== 8'd0 || BUSY !== 1'b0 || TIMEOUT !== 1'b0) begin
            fails++;
            $display("FAIL reset: GO=%b OV=%b SUM=%0d AVG=%0d BUSY=%b TO=%b, required all 0",
                     ADC_GO, OUT_VALID, OUT_SUM, OUT_AVG, BUSY, TIMEOUT);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        res_tab[0] = 8'd10; res_tab[1] = 8'd20; res_tab[2] = 8'd30; res_tab[3] = 8'd40;
        run_burst(2, 0, "basic_k2");
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 16; i++) res_tab[i] = 8'd255;
        run_burst(4, 0, "full_k4");
    endtask

    task automatic test_single();
        res_tab[0] = 8'd77;
        run_burst(0, 0, "single_k0");
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) res_tab[i] = 8'($urandom_range(0, 255));
        run_burst(7, 0, "clamp_k7");
    endtask

    task automatic test_level_ignored();
        exp_sum_q.push_back(50);
        exp_avg_q.push_back(50);
        START    = 1'b1;
        OSR_LOG2 = 3'd0;
        step();
        START      = 1'b0;
        ADC_VALID  = 1'b1;
        ADC_RESULT = 8'd99;
        for (int i = 0; i < 6; i++) step();
        tests++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL level_ignored: OUT_VALID=%b BUSY=%b, required 0/1", OUT_VALID, BUSY);
        end
        ADC_VALID = 1'b0;
        step();
        ADC_VALID  = 1'b1;
        ADC_RESULT = 8'd50;
        step();
        ADC_VALID  = 1'b0;
        tests++;
        if (OUT_VALID !== 1'b1) begin
            fails++;
            $display("FAIL level_edge: OUT_VALID=%b, required 1", OUT_VALID);
        end
        if (exp_sum_q.size() != 0) begin
            tests++;
            if (OUT_SUM !== 12'(exp_sum_q.pop_front()) || OUT_AVG !== 8'(exp_avg_q.pop_front())) begin
                fails++;
                $display("FAIL level_sum: SUM=%0d AVG=%0d, required 50/50", OUT_SUM, OUT_AVG);
            end
        end
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen_ov = 1'b0;
        START    = 1'b1;
        OSR_LOG2 = 3'd1;
        step();
        START = 1'b0;
        // One GO cycle followed by 64 WAIT cycles before the abort lands.
        while (BUSY === 1'b1 && n < 200) begin
            step();
            n++;
            if (OUT_VALID === 1'b1) seen_ov = 1'b1;
        end
        tests++;
        if (n != 65) begin
            fails++;
            $display("FAIL timeout_cycles: BUSY dropped after %0d cycles, required 65", n);
        end
        tests++;
        if (TIMEOUT !== 1'b1 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL timeout_flags: TIMEOUT=%b BUSY=%b, required 1/0", TIMEOUT, BUSY);
        end
        tests++;
        if (seen_ov) begin
            fails++;
            $display("FAIL timeout_no_out: OUT_VALID rose during aborted burst, required 0");
        end
        res_tab[0] = 8'd5;
        run_burst(0, 0, "after_timeout");
        tests++;
        if (TIMEOUT !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: TIMEOUT=%b, required 0", TIMEOUT);
        end
    endtask

    task automatic test_back_to_back();
        res_tab[0] = 8'd100; res_tab[1] = 8'd200;
        run_burst(1, 10, "backpressure_k1");
        res_tab[0] = 8'd7; res_tab[1] = 8'd9;
        run_burst(1, 0, "back_to_back_k1");
    endtask

    task automatic test_reset_mid();
        bit ok;
        START    = 1'b1;
        OSR_LOG2 = 3'd2;
        step();
        START = 1'b0;
        feed_sample(8'd60, ok);
        feed_sample(8'd70, ok);
        step();
        RST = 1'b1;
        #1;
        tests++;
        if (ADC_GO !== 1'b0 || OUT_VALID !== 1'b0 || OUT_SUM !== 12'd0 ||
            OUT_AVG !== 8'd0 || BUSY !== 1'b0 || TIMEOUT !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: GO=%b OV=%b SUM=%0d AVG=%0d BUSY=%b TO=%b, required all 0",
                     ADC_GO, OUT_VALID, OUT_SUM, OUT_AVG, BUSY, TIMEOUT);
        end
        step();
        RST = 1'b0;
        step();
        res_tab[0] = 8'd1; res_tab[1] = 8'd2; res_tab[2] = 8'd3; res_tab[3] = 8'd4;
        run_burst(2, 0, "after_reset");
    endtask

`ifdef SAR_OSC_WINDOW_EN
    task automatic test_window();
        WIN_LO = 8'd20;
        WIN_HI = 8'd30;
        res_tab[0] = 8'd10; res_tab[1] = 8'd20; res_tab[2] = 8'd30; res_tab[3] = 8'd40;
        run_burst(2, 0, "window_in");
        tests++;
        if (OUT_INWIN !== 1'b1) begin
            fails++;
            $display("FAIL window_in_flag: OUT_INWIN=%b, required 1", OUT_INWIN);
        end
        res_tab[0] = 8'd31;
        run_burst(0, 0, "window_out");
        tests++;
        if (OUT_INWIN !== 1'b0) begin
            fails++;
            $display("FAIL window_out_flag: OUT_INWIN=%b, required 0", OUT_INWIN);
        end
    endtask
`endif

    initial begin
        RST        = 1'b1;
        START      = 1'b0;
        OSR_LOG2   = 3'd0;
        ADC_VALID  = 1'b0;
        ADC_RESULT = 8'd0;
        OUT_READY  = 1'b0;
`ifdef SAR_OSC_WINDOW_EN
        WIN_LO     = 8'd20;
        WIN_HI     = 8'd30;
`endif
        test_reset();
        test_basic();
        test_full_scale();
        test_single();
        test_clamp();
        test_level_ignored();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef SAR_OSC_WINDOW_EN
        test_window();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
